// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
package mul_arb_pkg;

    localparam int MUL_W   = 32;
    localparam int RES_W   = 64;
    localparam int MUL_LAT = 2;
    localparam int STAT_W  = 16;

    // Requester tag carried alongside the multiplier stages; the top
    // uses only the low ID_W bits of id.
    typedef struct packed {
        logic       vld;
        logic [3:0] id;
    } mul_tag_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/result bundle between requesters and the shared multiplier.
// master = requester side, slave = arbiter side.
interface mul_share_arbiter_if #(
    parameter int NREQ = 4
);
    import mul_arb_pkg::*;

    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*MUL_W-1:0] req_a;
    logic [NREQ*MUL_W-1:0] req_b;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [RES_W-1:0]      res_r;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_id, res_r
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_id, res_r
    );

endinterface

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (wrapping) for the first
// asserted request; the winner becomes lowest priority next cycle.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] cand;
    logic           found;
    int             pos;

    // Pick the first requester at or after ptr; nothing is granted in reset.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N) pos = pos - N;
            cand = IDW'(pos);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_id    = cand;
                found     = 1'b1;
            end
        end
        if (reset) begin
            gnt    = '0;
            gnt_id = '0;
            found  = 1'b0;
        end
    end

    // Pointer moves just past the winner; holds when nobody is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/multiplier_pipelined.sv
// Two-stage unsigned W x W multiplier, no reset on the datapath.
// Stage 1 forms two half-width partial products, stage 2 sums them.
module multiplier_pipelined #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    localparam int H = W / 2;

    logic [W+H-1:0] pp_lo_d, pp_hi_d, pp_lo_q, pp_hi_q;
    logic [2*W-1:0] p_d, p_q;

    // Partial products against the low and high halves of b.
    always_comb begin
        pp_lo_d = (W+H)'(a) * (W+H)'(b[H-1:0]);
        pp_hi_d = (W+H)'(a) * (W+H)'(b[W-1:H]);
    end

    // Recombine: high partial product is weighted by 2^H.
    always_comb begin
        p_d = (2*W)'(pp_lo_q) + ((2*W)'(pp_hi_q) << H);
    end

    // Pipeline registers; contents are don't-care until a tagged result.
    always_ff @(posedge clk) begin
        pp_lo_q <= pp_lo_d;
        pp_hi_q <= pp_hi_d;
        p_q     <= p_d;
    end

    assign p = p_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one 2-stage multiplier among NREQ requesters. A grant in cycle t
// produces res_valid/res_id/res_r in cycle t+2. Requester IDs travel in a
// tag shift register that advances every cycle, so holes keep ordering.
// Optional MUL_ARB_STATS_EN adds per-requester grant and idle counters.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    mul_share_arbiter_if.slave      bus
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]  grant_cnt,
    output logic [STAT_W-1:0]       idle_cnt
`endif
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]  gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic [MUL_W-1:0] op_a, op_b;
    logic [RES_W-1:0] mul_p;
    mul_tag_t         tag_d;
    mul_tag_t         tag_q [MUL_LAT];

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (bus.req_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign gnt_any       = |gnt;
    assign bus.req_ready = gnt;

    // Operand mux: granted requester's pair, zeros when idle.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (gnt_any) begin
            op_a = bus.req_a[int'(gnt_id)*MUL_W +: MUL_W];
            op_b = bus.req_b[int'(gnt_id)*MUL_W +: MUL_W];
        end
    end

    multiplier_pipelined #(.W(MUL_W)) u_mul (
        .clk (clk),
        .a   (op_a),
        .b   (op_b),
        .p   (mul_p)
    );

    // Tag entering the pipe this cycle.
    always_comb begin
        tag_d     = '0;
        tag_d.vld = gnt_any;
        tag_d.id  = 4'(gnt_id);
    end

    // Tag shift register in lockstep with the multiplier; reset drops in-flight ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < MUL_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign bus.res_valid = tag_q[MUL_LAT-1].vld;
    assign bus.res_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
    assign bus.res_r     = mul_p;

`ifdef MUL_ARB_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] grant_cnt_q;
    logic [STAT_W-1:0]           idle_cnt_q;

    // Wrapping grant and idle counters, updated in the cycle of the event.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
            end
            if (!gnt_any) idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign idle_cnt  = idle_cnt_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: a constant vector table, hand sequences for
// mid-flight reset, and random traffic against a queue-based reference.
// With MUL_ARB_STATS_EN defined the counters are exercised as well.
module tb_mul_share_arbiter;
    import mul_arb_pkg::*;

    localparam int NREQ = 4;
    localparam logic [127:0] STD_A = {32'd5, 32'd4, 32'd3, 32'd2};
    localparam logic [127:0] STD_B = {32'd13, 32'd12, 32'd11, 32'd10};
    localparam logic [127:0] A7    = {32'd0, 32'd7, 64'd0};
    localparam logic [127:0] B6    = {32'd0, 32'd6, 64'd0};
    localparam logic [127:0] AONE  = {64'd0, 32'hFFFF_FFFF, 32'd0};
    localparam logic [127:0] A16   = {64'd0, 32'h0001_0000, 32'd0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NREQ(NREQ)) bus ();

`ifdef MUL_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] grant_cnt;
    logic [STAT_W-1:0]      idle_cnt;
`endif

    mul_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef MUL_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .idle_cnt  (idle_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: pointer plus a queue of results due at a given cycle.
    typedef struct {
        int          due;
        int          id;
        logic [63:0] r;
    } res_t;
    res_t q[$];
    int   m_ptr = 0;

    typedef struct {
        logic         rst;
        logic [3:0]   v;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   ready;
        logic         rv;
        logic [1:0]   id;
        logic [63:0]  r;
    } vec_t;
    vec_t tbl[28];

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [127:0] a, logic [127:0] b,
                                logic [3:0] ready, logic rv, logic [1:0] id, logic [63:0] r);
        vec_t t;
        t.rst = rst; t.v = v; t.a = a; t.b = b;
        t.ready = ready; t.rv = rv; t.id = id; t.r = r;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs, compare against the reference, update it.
    task automatic drive_and_check(input logic rst, input logic [3:0] v,
                                   input logic [127:0] a, input logic [127:0] b, output int g);
        reset         = rst;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
        g = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (g < 0 && v[c]) g = c;
            end
        end
        chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("res_valid", 64'(bus.res_valid), 64'd1);
            chk("res_id", 64'(bus.res_id), 64'(q[0].id));
            chk("res_r", bus.res_r, q[0].r);
            void'(q.pop_front());
        end else begin
            chk("res_valid", 64'(bus.res_valid), 64'd0);
        end
        if (rst) begin
            q.delete();
            m_ptr = 0;
        end else if (g >= 0) begin
            q.push_back('{due: cyc + 2, id: g,
                          r: 64'(a[32*g +: 32]) * 64'(b[32*g +: 32])});
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int g;
        logic [3:0]   v;
        logic [127:0] a, b;
        logic         pend [NREQ];
        logic [31:0]  pa [NREQ];
        logic [31:0]  pb [NREQ];

        // rst, valid, a, b | ready, res_valid, res_id, res_r
        tbl[0]  = mk(1, 4'hF, STD_A, STD_B, 4'h0, 0, 0, 0);
        tbl[1]  = mk(1, 4'hF, STD_A, STD_B, 4'h0, 0, 0, 0);
        tbl[2]  = mk(1, 4'hF, STD_A, STD_B, 4'h0, 0, 0, 0);
        tbl[3]  = mk(0, 4'hF, STD_A, STD_B, 4'h1, 0, 0, 0);
        tbl[4]  = mk(0, 4'hF, STD_A, STD_B, 4'h2, 0, 0, 0);
        tbl[5]  = mk(0, 4'hF, STD_A, STD_B, 4'h4, 1, 0, 64'd20);
        tbl[6]  = mk(0, 4'hF, STD_A, STD_B, 4'h8, 1, 1, 64'd33);
        tbl[7]  = mk(0, 4'hF, STD_A, STD_B, 4'h1, 1, 2, 64'd48);
        tbl[8]  = mk(0, 4'hF, STD_A, STD_B, 4'h2, 1, 3, 64'd65);
        tbl[9]  = mk(0, 4'hF, STD_A, STD_B, 4'h4, 1, 0, 64'd20);
        tbl[10] = mk(0, 4'hF, STD_A, STD_B, 4'h8, 1, 1, 64'd33);
        tbl[11] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 1, 2, 64'd48);
        tbl[12] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 1, 3, 64'd65);
        tbl[13] = mk(0, 4'h4, A7, B6, 4'h4, 0, 0, 0);
        tbl[14] = mk(0, 4'h0, A7, B6, 4'h0, 0, 0, 0);
        tbl[15] = mk(0, 4'h0, A7, B6, 4'h0, 1, 2, 64'd42);
        tbl[16] = mk(0, 4'h0, A7, B6, 4'h0, 0, 0, 0);
        tbl[17] = mk(0, 4'h2, AONE, AONE, 4'h2, 0, 0, 0);
        tbl[18] = mk(0, 4'h2, A16, A16, 4'h2, 0, 0, 0);
        tbl[19] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 1, 1, 64'hFFFF_FFFE_0000_0001);
        tbl[20] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 1, 1, 64'h0000_0001_0000_0000);
        tbl[21] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 0, 0, 0);
        tbl[22] = mk(0, 4'h3, STD_A, STD_B, 4'h1, 0, 0, 0);
        tbl[23] = mk(0, 4'h3, STD_A, STD_B, 4'h2, 0, 0, 0);
        tbl[24] = mk(0, 4'h1, STD_A, STD_B, 4'h1, 1, 0, 64'd20);
        tbl[25] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 1, 1, 64'd33);
        tbl[26] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 1, 0, 64'd20);
        tbl[27] = mk(0, 4'h0, STD_A, STD_B, 4'h0, 0, 0, 0);

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        @(posedge clk);
        #1;

        // Table phase: constant expectations plus the reference.
        for (int i = 0; i < 28; i++) begin
            drive_and_check(tbl[i].rst, tbl[i].v, tbl[i].a, tbl[i].b, g);
            chk($sformatf("tbl%0d_ready", i), 64'(bus.req_ready), 64'(tbl[i].ready));
            chk($sformatf("tbl%0d_rvalid", i), 64'(bus.res_valid), 64'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk($sformatf("tbl%0d_rid", i), 64'(bus.res_id), 64'(tbl[i].id));
                chk($sformatf("tbl%0d_r", i), bus.res_r, tbl[i].r);
            end
            advance();
        end

        // Reset while an op is in flight: nothing comes out, pointer restarts.
        drive_and_check(0, 4'hF, STD_A, STD_B, g);
        advance();
        drive_and_check(1, 4'hF, STD_A, STD_B, g);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        advance();
        drive_and_check(0, 4'h0, STD_A, STD_B, g);
        chk("mid_rst_rv_t2", 64'(bus.res_valid), 64'd0);
        advance();
        drive_and_check(0, 4'hF, STD_A, STD_B, g);
        chk("mid_rst_rv_t3", 64'(bus.res_valid), 64'd0);
        chk("mid_rst_ptr0", 64'(bus.req_ready), 64'd1);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive_and_check(0, 4'h0, STD_A, STD_B, g);
            advance();
        end

        // Random traffic; requesters hold their pair until transferred.
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; pa[i] = '0; pb[i] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    pb[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                end
                v[i] = pend[i];
                a[32*i +: 32] = pa[i];
                b[32*i +: 32] = pb[i];
            end
            drive_and_check(($urandom_range(0, 63) == 0), v, a, b, g);
            if (g >= 0) pend[g] = 1'b0;
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive_and_check(0, 4'h0, STD_A, STD_B, g);
            advance();
        end

`ifdef MUL_ARB_STATS_EN
        // Counters: 5 grants to requester 1, then 3 idle cycles.
        drive_and_check(1, 4'h0, STD_A, STD_B, g);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive_and_check(0, 4'h2, STD_A, STD_B, g);
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            drive_and_check(0, 4'h0, STD_A, STD_B, g);
            advance();
        end
        for (int i = 0; i < NREQ; i++) begin
            chk($sformatf("grant_cnt%0d", i), 64'(grant_cnt[16*i +: 16]), (i == 1) ? 64'd5 : 64'd0);
        end
        chk("idle_cnt", 64'(idle_cnt), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
